// File: rtl/xy_input_buffer.sv
// Per-port input FIFO of the mesh switch: buffers single-flit packets and
// presents the head flit plus its destination X/Y to route compute and crossbar.
module xy_input_buffer #(
    parameter int DATA_W          = 8,
    parameter int PACKET_ADDR_X_W = 4,
    parameter int PACKET_ADDR_Y_W = 4,
    parameter int BUFFER_DEPTH_W  = 2,
    localparam int FLIT_W         = PACKET_ADDR_X_W + PACKET_ADDR_Y_W + DATA_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [FLIT_W-1:0]          data_i,
    output logic                       full_o,
    output logic                       ovf_o,
    input  logic                       rd_en_i,
    output logic                       valid_o,
    output logic [FLIT_W-1:0]          data_o,
    output logic [PACKET_ADDR_X_W-1:0] x_addr_o,
    output logic [PACKET_ADDR_Y_W-1:0] y_addr_o,
    output logic [BUFFER_DEPTH_W:0]    count_o
);
    localparam int DEPTH = 1 << BUFFER_DEPTH_W;

    typedef struct packed {
        logic [PACKET_ADDR_X_W-1:0] x;
        logic [PACKET_ADDR_Y_W-1:0] y;
        logic [DATA_W-1:0]          payload;
    } flit_t;

    logic [FLIT_W-1:0]       mem [DEPTH];
    logic [BUFFER_DEPTH_W:0] wr_ptr, rd_ptr;
    logic                    empty, full;
    logic                    wr_acc, rd_acc;
    logic                    ovf_q;
    flit_t                   head;

    // Extra MSB on each pointer disambiguates full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[BUFFER_DEPTH_W-1:0] == rd_ptr[BUFFER_DEPTH_W-1:0]) &&
                   (wr_ptr[BUFFER_DEPTH_W] != rd_ptr[BUFFER_DEPTH_W]);

    // A pop while full frees the head slot in the same edge, so the write may land there.
    assign wr_acc = wr_en_i && (!full || rd_en_i);
    assign rd_acc = rd_en_i && !empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            ovf_q <= wr_en_i && full && !rd_en_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_acc) mem[wr_ptr[BUFFER_DEPTH_W-1:0]] <= data_i;
    end

    assign head     = flit_t'(mem[rd_ptr[BUFFER_DEPTH_W-1:0]]);
    assign data_o   = head;
    assign valid_o  = !empty;
    assign full_o   = full;
    assign ovf_o    = ovf_q;
    assign count_o  = wr_ptr - rd_ptr;
    assign x_addr_o = valid_o ? head.x : '0;
    assign y_addr_o = valid_o ? head.y : '0;

endmodule

// File: tb/tb_xy_input_buffer.sv
// Directed + random bench for xy_input_buffer against a queue-based FIFO model.
module tb_xy_input_buffer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        rd_en_i = 1'b0;
    logic        full_o, ovf_o, valid_o;
    logic [15:0] data_o;
    logic [3:0]  x_addr_o, y_addr_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    bit          exp_ovf = 1'b0;

    xy_input_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .data_i(data_i),
        .full_o(full_o), .ovf_o(ovf_o), .rd_en_i(rd_en_i), .valid_o(valid_o),
        .data_o(data_o), .x_addr_o(x_addr_o), .y_addr_o(y_addr_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count_o), 32'(q.size()));
        chk("valid", 32'(valid_o), 32'(q.size() != 0));
        chk("full", 32'(full_o), 32'(q.size() == 4));
        chk("ovf", 32'(ovf_o), 32'(exp_ovf));
        if (q.size() != 0) begin
            chk("data", 32'(data_o), 32'(q[0]));
            chk("x_addr", 32'(x_addr_o), 32'(q[0][15:12]));
            chk("y_addr", 32'(y_addr_o), 32'(q[0][11:8]));
        end else begin
            chk("x_zero", 32'(x_addr_o), 32'd0);
            chk("y_zero", 32'(y_addr_o), 32'd0);
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, then check.
    task automatic step(input bit r, input bit w, input logic [15:0] d, input bit rd);
        bit was_full;
        rst_i = r; wr_en_i = w; data_i = d; rd_en_i = rd;
        @(posedge clk_i);
        if (r) begin
            q.delete();
            exp_ovf = 1'b0;
        end else begin
            was_full = (q.size() == 4);
            exp_ovf  = w && was_full && !rd;
            if (rd && q.size() != 0) void'(q.pop_front());
            if (w && (!was_full || rd)) q.push_back(d);
        end
        #1;
        rst_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
        check_all();
    endtask

    initial begin
        int ovf_seen;
        // Reset and single flit
        step(1, 0, 16'h0, 0);
        step(1, 0, 16'h0, 0);
        chk("rst_count", 32'(count_o), 32'd0);
        step(0, 1, 16'h35A7, 0);
        chk("single_data", 32'(data_o), 32'h35A7);
        chk("single_x", 32'(x_addr_o), 32'd3);
        chk("single_y", 32'(y_addr_o), 32'd5);
        step(0, 0, 16'h0, 1);
        chk("single_pop_valid", 32'(valid_o), 32'd0);

        // Fill and overflow
        ovf_seen = 0;
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 16'(16'h0100 + i), 0);
            if (i == 4) chk("full_after_4", 32'(full_o), 32'd1);
            ovf_seen += int'(ovf_o);
        end
        step(0, 0, 16'h0, 0);
        ovf_seen += int'(ovf_o);
        chk("ovf_once", 32'(ovf_seen), 32'd1);
        chk("fill_count", 32'(count_o), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(data_o), 32'(16'h0100 + i));
            step(0, 0, 16'h0, 1);
        end

        // Full with simultaneous read/write
        for (int i = 1; i <= 4; i++) step(0, 1, 16'(16'h0200 + i), 0);
        step(0, 1, 16'h0F0F, 1);
        chk("rw_full_ovf", 32'(ovf_o), 32'd0);
        chk("rw_full_full", 32'(full_o), 32'd1);
        chk("rw_full_head", 32'(data_o), 32'h0202);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("rw_full_last", 32'(data_o), 32'h0F0F);
            step(0, 0, 16'h0, 1);
        end

        // Wrap-around: reads lag writes by 2 cycles
        for (int i = 0; i < 14; i++) begin
            step(0, i < 12, 16'(16'h1000 + i * 16'h0111), i >= 2);
            chk("wrap_cnt_le3", 32'(count_o <= 3), 32'd1);
            chk("wrap_no_ovf", 32'(ovf_o), 32'd0);
        end

        // Read+write while empty
        step(0, 1, 16'h7CE1, 1);
        chk("empty_rw_count", 32'(count_o), 32'd1);
        chk("empty_rw_head", 32'(data_o), 32'h7CE1);
        step(0, 0, 16'h0, 1);

        // Reset mid-operation with a concurrent write
        for (int i = 0; i < 3; i++) step(0, 1, 16'(16'h4400 + i), 0);
        step(1, 1, 16'hBEEF, 0);
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_full", 32'(full_o), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
                 16'($urandom), $urandom_range(0, 1) == 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xy_input_buffer.md
Name: xy_input_buffer

Overview:
- Per-port input FIFO of a mesh switch, one instance on each of the RESOURCE, WEST, EAST, NORTH and SOUTH inputs.
- Stores incoming single-flit packets and exposes the head flit's destination X/Y fields to the XY route-compute stage.
- Exposes the head flit itself to the crossbar and pops it when the crossbar grants the port.
- Flit format, MSB to LSB: {x_addr, y_addr, payload}.

Parameters:
- DATA_W, 8, payload width in bits.
- PACKET_ADDR_X_W, 4, destination X field width.
- PACKET_ADDR_Y_W, 4, destination Y field width.
- BUFFER_DEPTH_W, 2, log2 of FIFO depth (default depth 4); legal range 1..6.
- Derived, not overridable: FLIT_W = PACKET_ADDR_X_W + PACKET_ADDR_Y_W + DATA_W.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  upstream write request.
- data_i  in  FLIT_W  flit to store.
- full_o  out  1  FIFO full; upstream must not rely on a write landing while high unless rd_en_i is high in the same cycle.
- ovf_o  out  1  one-cycle pulse: a write was refused.
- rd_en_i  in  1  crossbar pop of the head flit.
- valid_o  out  1  head flit present (not empty).
- data_o  out  FLIT_W  head flit.
- x_addr_o  out  PACKET_ADDR_X_W  head destination X, to the route-compute stage.
- y_addr_o  out  PACKET_ADDR_Y_W  head destination Y, to the route-compute stage.
- count_o  out  BUFFER_DEPTH_W+1  current occupancy, 0..2^BUFFER_DEPTH_W.

Behaviour:
- Storage
  - Circular buffer of 2^BUFFER_DEPTH_W entries.
  - Read and write pointers are BUFFER_DEPTH_W+1 bits wide; the MSB is the wrap bit.
  - Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ.
  - Storage array is not reset.
- Reset
  - rst_i high at a clock edge sets pointers=0, count_o=0, valid_o=0, full_o=0, ovf_o=0.
  - Any flits held are discarded, including when reset arrives mid-traffic.
  - wr_en_i and rd_en_i are ignored in a reset cycle.
- Write
  - Accepted when wr_en_i && (!full_o || rd_en_i).
  - An accepted write stores data_i at the write pointer and increments the write pointer.
  - Refused when wr_en_i && full_o && !rd_en_i; ovf_o=1 on the next cycle only. The flit is dropped and state is unchanged.
- Read
  - Effective when rd_en_i && valid_o; increments the read pointer.
  - rd_en_i while empty is ignored, with no pointer change and no error.
- Outputs and latency
  - data_o = storage[read pointer], combinational from the registered pointer.
  - A flit written at edge N appears on data_o, x_addr_o, y_addr_o and valid_o after edge N, i.e. 1-cycle latency.
  - There is no same-cycle write-to-read bypass.
  - x_addr_o and y_addr_o are slices of data_o when valid_o=1, and are forced to 0 when valid_o=0.
  - full_o, valid_o and count_o are registered state or decoded directly from it; there is no combinational path from wr_en_i or rd_en_i.
- Simultaneous read and write
  - Occupancy is unchanged, both pointers advance, count_o holds.
  - When empty, only the write takes effect and count becomes 1.
  - When full, both take effect; the new flit enters the slot freed by the pop and full_o stays 1.
- Wrap-around
  - Pointers wrap modulo 2^(BUFFER_DEPTH_W+1).
  - Order is strictly FIFO across the wrap.
- Arithmetic: count_o = write pointer - read pointer, modulo 2^(BUFFER_DEPTH_W+1).

Test Plan:
- Reset and single flit: rst_i=1 for 2 cycles, then write data_i=0x35A7 (x=3, y=5, payload 0xA7) → next cycle valid_o=1, x_addr_o=3, y_addr_o=5, data_o=0x35A7, count_o=1; then rd_en_i=1 → valid_o=0, x_addr_o=0, y_addr_o=0, count_o=0.
- Fill and overflow: 5 consecutive writes 0x0101..0x0105 with no reads → full_o=1 after the 4th; the 5th is refused, ovf_o pulses exactly once, count_o=4; draining returns 0x0101..0x0104 in order.
- Full with simultaneous read/write: at count_o=4, wr_en_i=1 and rd_en_i=1 with data 0x0F0F → no ovf_o, full_o stays 1, count_o=4; the head advances and 0x0F0F is the last flit out.
- Wrap-around: 12 flits streamed with reads lagging by 2 cycles → output sequence identical to input, count_o never exceeds 3, no ovf_o.
- Read on empty plus write-only-on-empty: rd_en_i=1 with wr_en_i=1 while empty → count_o=1 next cycle and the written flit is at the head.
- Reset mid-operation: 3 flits held, assert rst_i with wr_en_i=1 in the same cycle → next cycle count_o=0, valid_o=0, full_o=0; no flit is stored.
